// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ packet sources.
// A grant is held until the packet's last beat or MAXBURST accepted beats, then re-arbitrated.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DBITS    = 16,
  parameter int unsigned MAXBURST = 8
) (
  input  logic                     wrclk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DBITS-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     wr_en,
  output logic [DBITS-1:0]         wr_data,
  input  logic                     wr_full,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int unsigned IdW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(MAXBURST + 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  grant_q, grant_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic           found;
  logic [IdW-1:0] pick;
  logic [IdW-1:0] cand;

  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= IdW'(NREQ - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // First valid requester after ptr, wrapping explicitly so non-power-of-2 NREQ works.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = ptr_q;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = (cand == IdW'(NREQ - 1)) ? '0 : cand + IdW'(1);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    req_ready = '0;
    wr_en     = 1'b0;
    wr_data   = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          count_d = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        req_ready[grant_q] = ~wr_full;
        wr_en              = req_valid[grant_q] & ~wr_full;
        wr_data            = req_data[int'(grant_q)*DBITS +: DBITS];
        if (wr_en) begin
          count_d = count_q + CntW'(1);
          // last and burst cap on the same beat collapse into one release
          if (req_last[grant_q] || count_d == CntW'(MAXBURST)) begin
            state_d = StIdle;
            ptr_d   = grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == StGrant);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table plus hand-written
// sequences for burst cap, FIFO-full stall, owner lock and mid-packet reset.
module tb_fifo_wr_arbiter;

  logic        wrclk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [63:0] req_data;
  logic        wr_en, wr_full, busy;
  logic [15:0] wr_data;
  logic [1:0]  grant_id;
  logic [15:0] src [4];

  int n_vec = 0;
  int n_err = 0;

  always_comb req_data = {src[3], src[2], src[1], src[0]};
  always #5 wrclk = ~wrclk;

  fifo_wr_arbiter #(
    .NREQ(4),
    .DBITS(16),
    .MAXBURST(8)
  ) dut (
    .wrclk(wrclk),
    .rst(rst),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_data(req_data),
    .req_ready(req_ready),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_full(wr_full),
    .grant_id(grant_id),
    .busy(busy)
  );

  typedef struct {
    logic       r;
    logic [3:0] v;
    logic [3:0] l;
    logic       f;
    logic       eb;
    logic [3:0] er;
    logic       ee;
    logic [1:0] eg;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %h expected %h", n_vec, name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, compare outputs at the falling edge, advance past the rising edge.
  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic f,
                      input logic eb, input logic [3:0] er, input logic ee,
                      input logic [1:0] eg, input logic cd, input logic [15:0] ed);
    req_valid = v;
    req_last  = l;
    wr_full   = f;
    @(negedge wrclk);
    n_vec++;
    chk("busy", busy, eb);
    chk("req_ready", req_ready, er);
    chk("wr_en", wr_en, ee);
    chk("grant_id", grant_id, eg);
    if (cd) chk("wr_data", wr_data, ed);
    @(posedge wrclk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    wr_full   = 1'b0;
    #2;
    n_vec++;
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_grant", grant_id, 0);
    @(posedge wrclk);
    #1;
    rst = 1'b0;
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                     input logic eb, input logic [3:0] er, input logic ee, input logic [1:0] eg);
    vec_t t;
    t.r = r; t.v = v; t.l = l; t.f = f; t.eb = eb; t.er = er; t.ee = ee; t.eg = eg;
    tbl.push_back(t);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    wr_full = 1'b0;
    for (int i = 0; i < 4; i++) src[i] = 16'hA000 + 16'(i) * 16'h0111;

    // Req0 alone, 3-beat packet
    add(0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    add(0, 4'b0001, 4'b0000, 0, 1, 4'b0001, 1, 2'd0);
    add(0, 4'b0001, 4'b0000, 0, 1, 4'b0001, 1, 2'd0);
    add(0, 4'b0001, 4'b0001, 0, 1, 4'b0001, 1, 2'd0);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    // Reset, then all four with 2-beat packets: order 0,1,2,3,0
    add(1, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    add(0, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    for (int g = 0; g < 5; g++) begin
      logic [3:0] oh;
      logic [1:0] gi;
      gi = 2'(g % 4);
      oh = 4'b0001 << gi;
      add(0, 4'b1111, 4'b0000, 0, 1, oh, 1, gi);
      add(0, 4'b1111, 4'b1111, 0, 1, oh, 1, gi);
      add(0, (g == 4) ? 4'b0000 : 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, gi);
    end

    @(posedge wrclk);
    #1;
    do_reset();

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      step(tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].eb, tbl[i].er, tbl[i].ee, tbl[i].eg,
           1'b1, tbl[i].eb ? src[tbl[i].eg] : 16'h0000);
      rst = 1'b0;
    end

    // Burst cap: req2 12-beat packet, req3 1-beat packets
    do_reset();
    src[2] = 16'h2000;
    step(4'b1100, 4'b1000, 0, 0, 4'b0000, 0, 2'd0, 1, 16'h0000);
    for (int b = 0; b < 8; b++) begin
      src[2] = 16'h2000 + 16'(b);
      step(4'b1100, {1'b1, 1'(b == 11), 2'b00}, 0, 1, 4'b0100, 1, 2'd2, 1, src[2]);
    end
    src[2] = 16'h2008;
    src[3] = 16'h3000;
    step(4'b1100, 4'b1000, 0, 0, 4'b0000, 0, 2'd2, 1, 16'h0000);
    step(4'b1100, 4'b1000, 0, 1, 4'b1000, 1, 2'd3, 1, 16'h3000);
    step(4'b1100, 4'b1000, 0, 0, 4'b0000, 0, 2'd3, 1, 16'h0000);
    for (int b = 8; b < 12; b++) begin
      src[2] = 16'h2000 + 16'(b);
      step(4'b1100, {1'b1, 1'(b == 11), 2'b00}, 0, 1, 4'b0100, 1, 2'd2, 1, src[2]);
    end
    step(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 2'd2, 1, 16'h0000);

    // FIFO full for 5 cycles mid-burst on req1
    do_reset();
    src[1] = 16'h1100;
    step(4'b0010, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 1, 16'h0000);
    for (int b = 0; b < 2; b++) begin
      src[1] = 16'h1100 + 16'(b);
      step(4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 2'd1, 1, src[1]);
    end
    src[1] = 16'h1102;
    for (int c = 0; c < 5; c++) step(4'b0010, 4'b0000, 1, 1, 4'b0000, 0, 2'd1, 0, 16'h0000);
    for (int b = 2; b < 4; b++) begin
      src[1] = 16'h1100 + 16'(b);
      step(4'b0010, (b == 3) ? 4'b0010 : 4'b0000, 0, 1, 4'b0010, 1, 2'd1, 1, src[1]);
    end
    step(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 2'd1, 1, 16'h0000);

    // Owner req0 drops valid for 3 cycles while req1 waits
    do_reset();
    step(4'b0011, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 1, 16'h0000);
    step(4'b0011, 4'b0000, 0, 1, 4'b0001, 1, 2'd0, 1, src[0]);
    for (int c = 0; c < 3; c++) step(4'b0010, 4'b0000, 0, 1, 4'b0001, 0, 2'd0, 1, src[0]);
    step(4'b0011, 4'b0001, 0, 1, 4'b0001, 1, 2'd0, 1, src[0]);
    step(4'b0010, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 1, 16'h0000);
    step(4'b0010, 4'b0010, 0, 1, 4'b0010, 1, 2'd1, 1, src[1]);
    step(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 2'd1, 1, 16'h0000);

    // Asynchronous reset during beat 2 of a 4-beat packet
    do_reset();
    src[0] = 16'h6000;
    step(4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 1, 16'h0000);
    step(4'b1111, 4'b0000, 0, 1, 4'b0001, 1, 2'd0, 1, 16'h6000);
    src[0] = 16'h6001;
    req_valid = 4'b1111;
    req_last = 4'b0000;
    #1;
    n_vec++;
    chk("pre_rst_wr_en", wr_en, 1);
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    chk("async_busy", busy, 0);
    chk("async_wr_en", wr_en, 0);
    chk("async_ready", req_ready, 0);
    chk("async_wr_data", wr_data, 0);
    chk("async_grant", grant_id, 0);
    @(posedge wrclk);
    #1;
    rst = 1'b0;
    step(4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 1, 16'h0000);
    step(4'b1111, 4'b0000, 0, 1, 4'b0001, 1, 2'd0, 1, 16'h6001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
